// File: rtl/parking_time_recorder_pkg.sv
// Shared parking-fee datapath definitions: default widths, FSM encoding and
// a slot-index range check used by the recorder.
package parking_defs;

  localparam int TIME_W  = 8;
  localparam int N_SLOTS = 8;
  localparam int SLOT_W  = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  // Widened compare so it stays meaningful when 2^SLOT_W > N_SLOTS.
  function automatic logic slot_valid(input logic [31:0] idx, input int n);
    return idx < 32'(n);
  endfunction

endpackage

// File: rtl/parking_time_recorder_if.sv
// Event inputs and time_in/time_out report channel of the parking recorder.
// Report handshake: a pair transfers on any rising edge where out_valid && out_ready;
// while out_valid && !out_ready the pair is held stable, and out_valid never drops
// without a transfer (except on reset). exit_ready is high only when an exit can be taken.
interface parking_time_recorder_if #(
  parameter int SLOT_W = 3,
  parameter int TIME_W = 8
);
  logic              car_in;
  logic [SLOT_W-1:0] in_slot;
  logic              car_out;
  logic [SLOT_W-1:0] out_slot;
  logic              exit_ready;
  logic [TIME_W-1:0] time_in;
  logic [TIME_W-1:0] time_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output car_in, in_slot, car_out, out_slot, out_ready,
    input  exit_ready, time_in, time_out, out_valid
  );

  modport slave (
    input  car_in, in_slot, car_out, out_slot, out_ready,
    output exit_ready, time_in, time_out, out_valid
  );
endinterface

// File: rtl/parking_time_recorder_time_base.sv
// Free-running wrapping time base; advances once per tick strobe.
module park_time_base #(
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  output logic [TIME_W-1:0] now
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       now <= '0;
    else if (tick) now <= now + 1'b1;
  end

endmodule

// File: rtl/parking_time_recorder.sv
// Records per-slot entry timestamps and, on an exit, presents the matched
// time_in/time_out pair to the downstream difference calculator.
module parking_time_recorder
  import parking_defs::*;
#(
  parameter int N_SLOTS = parking_defs::N_SLOTS,
  parameter int SLOT_W  = parking_defs::SLOT_W,
  parameter int TIME_W  = parking_defs::TIME_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  parking_time_recorder_if.slave   bus,
  output logic [N_SLOTS-1:0]       occupied,
  output logic                     full,
  output logic                     err,
  output state_t                   state_dbg
);

  logic [TIME_W-1:0]  now;
  logic [TIME_W-1:0]  entry [N_SLOTS];
  logic [N_SLOTS-1:0] occ_q, occ_d;
  logic [TIME_W-1:0]  time_in_q, time_out_q;
  state_t             state_q, state_d;
  logic               entry_ok, exit_ok, err_q, err_d;

  park_time_base #(.TIME_W(TIME_W)) u_time_base (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .now  (now)
  );

  // Both events are judged against start-of-cycle occupancy, so a same-slot
  // entry+exit pair can never both succeed.
  always_comb begin
    entry_ok = 1'b0;
    exit_ok  = 1'b0;
    err_d    = 1'b0;
    occ_d    = occ_q;
    state_d  = state_q;

    entry_ok = bus.car_in && slot_valid(32'(bus.in_slot), N_SLOTS)
               && !occ_q[bus.in_slot];
    exit_ok  = bus.car_out && (state_q == ST_IDLE)
               && slot_valid(32'(bus.out_slot), N_SLOTS) && occ_q[bus.out_slot];
    err_d    = (bus.car_in && !entry_ok) || (bus.car_out && !exit_ok);

    if (exit_ok)  occ_d[bus.out_slot] = 1'b0;
    if (entry_ok) occ_d[bus.in_slot]  = 1'b1;

    case (state_q)
      ST_IDLE:   if (exit_ok) state_d = ST_REPORT;
      ST_REPORT: if (bus.out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      err_q      <= 1'b0;
      time_in_q  <= '0;
      time_out_q <= '0;
      for (int i = 0; i < N_SLOTS; i++) entry[i] <= '0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
      if (exit_ok) begin
        time_in_q  <= entry[bus.out_slot];
        time_out_q <= now;
      end
      if (entry_ok) entry[bus.in_slot] <= now;
    end
  end

  assign bus.out_valid  = (state_q == ST_REPORT);
  assign bus.exit_ready = (state_q == ST_IDLE);
  assign bus.time_in    = time_in_q;
  assign bus.time_out   = time_out_q;
  assign occupied       = occ_q;
  assign full           = &occ_q;
  assign err            = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_parking_time_recorder.sv
// Directed bench for parking_time_recorder: event sequences with hand-computed
// timestamps plus a vector table for fill/full/reject behaviour.
module tb_parking_time_recorder;
  import parking_defs::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   tick;
  logic [7:0] occupied;
  logic   full;
  logic   err;
  state_t state_dbg;
  int     checks = 0;
  int     failures = 0;

  parking_time_recorder_if #(.SLOT_W(3), .TIME_W(8)) bus ();

  parking_time_recorder dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .bus       (bus.slave),
    .occupied  (occupied),
    .full      (full),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  typedef struct {
    logic       tick;
    logic       car_in;
    logic [2:0] in_slot;
    logic       car_out;
    logic [2:0] out_slot;
    logic       out_ready;
    logic       e_err;
    logic       e_valid;
    logic       e_ready;
    logic [7:0] e_occ;
    logic       e_full;
    logic [7:0] e_ti;
    logic [7:0] e_to;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic t, input logic ci, input logic [2:0] is,
                       input logic co, input logic [2:0] os, input logic ordy);
    tick          = t;
    bus.car_in    = ci;
    bus.in_slot   = is;
    bus.car_out   = co;
    bus.out_slot  = os;
    bus.out_ready = ordy;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    repeat (n) step();
    idle();
  endtask

  task automatic chk_pair(input string name, input logic [7:0] ti, input logic [7:0] to);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_time_in"}, 32'(bus.time_in), 32'(ti));
    chk({name, "_time_out"}, 32'(bus.time_out), 32'(to));
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_exit_ready", 32'(bus.exit_ready), 32'd1);
    chk("rst_occupied", 32'(occupied), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_time_in", 32'(bus.time_in), 32'd0);
    chk("rst_time_out", 32'(bus.time_out), 32'd0);
    #10 rst = 1'b0;

    // Basic stay: entry sampled pre-increment at now=100 while tick is high.
    ticks(100);
    drive(1'b1, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1); step();
    chk("t1_occ_in", 32'(occupied), 32'h04);
    ticks(149);
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1); step();
    chk_pair("t1", 8'd100, 8'd250);
    chk("t1_occ_out", 32'(occupied), 32'h00);
    chk("t1_exit_ready_low", 32'(bus.exit_ready), 32'd0);
    idle(); step();
    chk("t1_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("t1_exit_ready_back", 32'(bus.exit_ready), 32'd1);

    // Wrap: 250 + 206 = 200 mod 256; 200 + 60 = 4 mod 256.
    ticks(206);
    drive(1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1); step();
    chk("t2_occ_in", 32'(occupied), 32'h20);
    ticks(60);
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1); step();
    chk_pair("t2", 8'd200, 8'd4);
    chk("t2_diff", 32'(8'(bus.time_out - bus.time_in)), 32'd60);
    idle(); step();

    // Back-pressure: pair held, second exit rejected while in REPORT.
    drive(1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1); step();
    ticks(10);
    drive(1'b0, 1'b1, 3'd6, 1'b0, 3'd0, 1'b1); step();
    chk("t3_occ_in", 32'(occupied), 32'h41);
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0); step();
    chk_pair("t3_exit", 8'd4, 8'd14);
    chk("t3_state", 32'(state_dbg), 32'(ST_REPORT));
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 3'd0, (k == 1), 3'd6, 1'b0); step();
      chk_pair("t3_hold", 8'd4, 8'd14);
      chk("t3_hold_exit_ready", 32'(bus.exit_ready), 32'd0);
      chk("t3_hold_err", 32'(err), 32'(k == 1));
      chk("t3_hold_occ", 32'(occupied), 32'h40);
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1); step();
    chk("t3_done_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_done_exit_ready", 32'(bus.exit_ready), 32'd1);

    // Fill / reject table at now=19, starting with slot 6 occupied.
    //         tk  ci  is    co  os    rdy  err valid rdy occ     full ti     to
    vt[0]  = '{0, 1, 3'd0, 0, 3'd0, 1, 0, 0, 1, 8'h41, 0, 8'd0,  8'd0};
    vt[1]  = '{0, 1, 3'd1, 0, 3'd0, 1, 0, 0, 1, 8'h43, 0, 8'd0,  8'd0};
    vt[2]  = '{0, 1, 3'd2, 0, 3'd0, 1, 0, 0, 1, 8'h47, 0, 8'd0,  8'd0};
    vt[3]  = '{0, 1, 3'd3, 0, 3'd0, 1, 0, 0, 1, 8'h4F, 0, 8'd0,  8'd0};
    vt[4]  = '{0, 1, 3'd4, 0, 3'd0, 1, 0, 0, 1, 8'h5F, 0, 8'd0,  8'd0};
    vt[5]  = '{0, 1, 3'd5, 0, 3'd0, 1, 0, 0, 1, 8'h7F, 0, 8'd0,  8'd0};
    vt[6]  = '{0, 1, 3'd7, 0, 3'd0, 1, 0, 0, 1, 8'hFF, 1, 8'd0,  8'd0};
    vt[7]  = '{0, 1, 3'd3, 0, 3'd0, 1, 1, 0, 1, 8'hFF, 1, 8'd0,  8'd0};
    vt[8]  = '{0, 1, 3'd6, 0, 3'd0, 1, 1, 0, 1, 8'hFF, 1, 8'd0,  8'd0};
    vt[9]  = '{0, 0, 3'd0, 1, 3'd3, 1, 0, 1, 0, 8'hF7, 0, 8'd19, 8'd19};
    vt[10] = '{0, 0, 3'd0, 0, 3'd0, 1, 0, 0, 1, 8'hF7, 0, 8'd0,  8'd0};
    vt[11] = '{0, 0, 3'd0, 1, 3'd3, 1, 1, 0, 1, 8'hF7, 0, 8'd0,  8'd0};
    vt[12] = '{0, 0, 3'd0, 0, 3'd0, 1, 0, 0, 1, 8'hF7, 0, 8'd0,  8'd0};
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].tick, vt[i].car_in, vt[i].in_slot, vt[i].car_out, vt[i].out_slot,
            vt[i].out_ready);
      step();
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].e_err));
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d_exit_ready", i), 32'(bus.exit_ready), 32'(vt[i].e_ready));
      chk($sformatf("vec%0d_occ", i), 32'(occupied), 32'(vt[i].e_occ));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vt[i].e_full));
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_time_in", i), 32'(bus.time_in), 32'(vt[i].e_ti));
        chk($sformatf("vec%0d_time_out", i), 32'(bus.time_out), 32'(vt[i].e_to));
      end
    end

    // Same-cycle events around now=144.
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b1); step();
    chk_pair("t5_clear1", 8'd19, 8'd19);
    idle(); step();
    ticks(125);
    drive(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b1); step();
    chk("t5_occ_in1", 32'(occupied), 32'hF7);
    drive(1'b0, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1); step();
    chk_pair("t5_diff_slots", 8'd144, 8'd144);
    chk("t5_diff_slots_occ", 32'(occupied), 32'hFD);
    chk("t5_diff_slots_err", 32'(err), 32'd0);
    idle(); step();
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1); step();
    chk_pair("t5_slot3_entry", 8'd144, 8'd144);
    idle(); step();
    drive(1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 1'b1); step();
    chk("t5_free_both_err", 32'(err), 32'd1);
    chk("t5_free_both_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_free_both_occ", 32'(occupied), 32'hFD);
    drive(1'b0, 1'b1, 3'd4, 1'b1, 3'd4, 1'b1); step();
    chk_pair("t5_occ_both", 8'd19, 8'd144);
    chk("t5_occ_both_err", 32'(err), 32'd1);
    chk("t5_occ_both_occ", 32'(occupied), 32'hED);
    idle(); step();
    chk("t5_err_pulse_end", 32'(err), 32'd0);

    // Asynchronous reset in the middle of REPORT.
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0); step();
    chk_pair("t6_pending", 8'd144, 8'd144);
    #3;
    rst = 1'b1;
    idle();
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_occ", 32'(occupied), 32'd0);
    chk("t6_rst_time_in", 32'(bus.time_in), 32'd0);
    chk("t6_rst_time_out", 32'(bus.time_out), 32'd0);
    chk("t6_rst_exit_ready", 32'(bus.exit_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("t6_post_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 1'b1); step();
    chk("t6_post_occ", 32'(occupied), 32'h04);
    ticks(3);
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1); step();
    chk_pair("t6_post_pair", 8'd0, 8'd3);
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
